// File: rtl/gcd_engine.sv
// gcd_engine: greatest common divisor of two unsigned operands by repeated
// compare / swap / subtract, one step per clock, with a start/done handshake,
// a saturating iteration counter and an optional equal-operand early exit.
//
// Handshake: `start` is a request that is only looked at while `busy` is low;
// the edge that sees start=1 in IDLE captures a_in/b_in and raises `busy`.
// Completion is a single-cycle `done` pulse; `result` is valid from that
// cycle and held until the next completion or reset. There is no
// back-pressure on `done`; the host must sample it in the pulse cycle.
module gcd_engine #(
    parameter int WIDTH    = 16,
    parameter int ITER_W   = 17,
    parameter int EARLY_EQ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [ITER_W-1:0] iters,
    output logic              state_dbg
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    localparam logic EARLY_EN = (EARLY_EQ != 0);

    logic             state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    // busy is a straight decode of the state register, so no input reaches
    // any output within the same cycle.
    assign busy      = (state == RUN);
    assign state_dbg = state;

    // Controller and datapath: capture, swap/subtract steps, completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            done   <= 1'b0;
            result <= '0;
            iters  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= a_in;
                        y     <= b_in;
                        iters <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Every RUN edge counts, including the terminating one;
                    // the counter sticks at all-ones instead of wrapping.
                    if (iters != {ITER_W{1'b1}}) begin
                        iters <= iters + 1'b1;
                    end
                    if (y == '0) begin
                        result <= x;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else if (EARLY_EN && (x == y)) begin
                        result <= x;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else if (x < y) begin
                        x <= y;
                        y <= x;
                    end else begin
                        x <= x - y;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: three instances (plain subtract/swap,
// early equal exit, and a narrow one with a small saturating counter),
// driven with directed vectors whose step counts were worked out by hand.
module tb_gcd_engine;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start0, start1, start2;
    logic [15:0] a0, b0, a1, b1;
    logic [7:0]  a2, b2;

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] result0, result1;
    logic [7:0]  result2;
    logic [16:0] iters0, iters1;
    logic [3:0]  iters2;
    logic        st0, st1, st2;

    gcd_engine #(.WIDTH(16), .ITER_W(17), .EARLY_EQ(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .a_in(a0), .b_in(b0),
        .busy(busy0), .done(done0), .result(result0), .iters(iters0),
        .state_dbg(st0)
    );

    gcd_engine #(.WIDTH(16), .ITER_W(17), .EARLY_EQ(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .result(result1), .iters(iters1),
        .state_dbg(st1)
    );

    gcd_engine #(.WIDTH(8), .ITER_W(4), .EARLY_EQ(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a_in(a2), .b_in(b2),
        .busy(busy2), .done(done2), .result(result2), .iters(iters2),
        .state_dbg(st2)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // done pulse counters, sampled on the falling edge
    int cnt0 = 0, cnt1 = 0, cnt2 = 0;
    always @(negedge clk) begin
        if (done0) cnt0++;
        if (done1) cnt1++;
        if (done2) cnt2++;
    end

    // ---------------- driver helpers ----------------
    task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b, input logic s);
        case (sel)
            0: begin start0 = s; a0 = a; b0 = b; end
            1: begin start1 = s; a1 = a; b1 = b; end
            default: begin start2 = s; a2 = a[7:0]; b2 = b[7:0]; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [31:0] get_result(input int sel);
        case (sel)
            0: return 32'(result0);
            1: return 32'(result1);
            default: return 32'(result2);
        endcase
    endfunction

    function automatic logic [31:0] get_iters(input int sel);
        case (sel)
            0: return 32'(iters0);
            1: return 32'(iters1);
            default: return 32'(iters2);
        endcase
    endfunction

    // Called #1 after the accepting edge; counts edges until done is seen.
    task automatic wait_done(input int sel, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!get_done(sel) && cyc < budget);
        if (!get_done(sel)) cyc = -1;
    endtask

    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input int exp_res, input int exp_cyc, input int exp_it,
                          input string tag);
        int cyc;
        @(negedge clk);
        drive(sel, a, b, 1'b1);
        @(posedge clk);
        #1;
        drive(sel, a, b, 1'b0);
        check({tag, "_busy"}, 32'(get_busy(sel)), 1);
        wait_done(sel, 400, cyc);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_result"}, get_result(sel), exp_res);
        check({tag, "_iters"}, get_iters(sel), exp_it);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 32'(get_done(sel)), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int base;
        reset = 1'b0;
        drive(0, 16'd0, 16'd0, 1'b0);
        drive(1, 16'd0, 16'd0, 1'b0);
        drive(2, 16'd0, 16'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy0),   0);
        check("rst_done",   32'(done0),   0);
        check("rst_result", 32'(result0), 0);
        check("rst_iters",  32'(iters0),  0);
        @(negedge clk);
        reset = 1'b1;

        // plain subtract/swap and early-exit variants
        run_op(0, 16'd12, 16'd8, 4, 6, 6, "p_12_8");
        run_op(1, 16'd12, 16'd8, 4, 4, 4, "e_12_8");
        run_op(0, 16'd5,  16'd5, 5, 3, 3, "p_5_5");
        run_op(1, 16'd5,  16'd5, 5, 1, 1, "e_5_5");
        run_op(0, 16'd9,  16'd6, 3, 6, 6, "p_9_6");

        // zero operands
        run_op(0, 16'd0, 16'd0, 0, 1, 1, "z_0_0");
        run_op(0, 16'd7, 16'd0, 7, 1, 1, "z_7_0");
        run_op(0, 16'd0, 16'd5, 5, 2, 2, "z_0_5");
        run_op(1, 16'd0, 16'd5, 5, 2, 2, "ez_0_5");

        // start held high during busy with other operands, then back-to-back
        @(negedge clk);
        drive(0, 16'd12, 16'd8, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 16'd100, 16'd75, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        drive(0, 16'd100, 16'd75, 1'b0);
        wait_done(0, 50, cyc);
        check("hold_cycles", cyc + 3, 6);
        check("hold_result", 32'(result0), 4);
        check("hold_iters",  32'(iters0),  6);
        // done is high now: request the next operation in this very cycle
        drive(0, 16'd9, 16'd6, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 16'd9, 16'd6, 1'b0);
        check("b2b_busy",        32'(busy0),   1);
        check("b2b_iters_clear", 32'(iters0),  0);
        check("b2b_result_kept", 32'(result0), 4);
        wait_done(0, 50, cyc);
        check("b2b_cycles", cyc, 6);
        check("b2b_result", 32'(result0), 3);
        check("b2b_iters",  32'(iters0),  6);

        // saturation on the narrow instance: 257 steps, counter stops at 15
        @(negedge clk);
        base = cnt2;
        run_op(2, 16'd255, 16'd1, 1, 257, 15, "sat");
        repeat (3) @(posedge clk);
        #1;
        check("sat_done_once", cnt2 - base, 1);

        // reset in the middle of a long operation
        @(negedge clk);
        drive(0, 16'hFFFF, 16'd1, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 16'hFFFF, 16'd1, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        base = cnt0;
        reset = 1'b0;
        #1;
        check("mid_rst_busy",   32'(busy0),   0);
        check("mid_rst_done",   32'(done0),   0);
        check("mid_rst_result", 32'(result0), 0);
        check("mid_rst_iters",  32'(iters0),  0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_no_done", cnt0 - base, 0);
        check("mid_rst_idle",    32'(busy0), 0);
        run_op(0, 16'd9, 16'd6, 3, 6, 6, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised greatest-common-divisor engine that merges the subtract/swap controller and its datapath into one block with a start/done handshake. It computes gcd(a, b) of two unsigned WIDTH-bit operands by repeated compare, swap and subtract, one step per clock. It sits as a self-contained arithmetic slave: a host drives `start` with operands and collects `result` on `done`. It adds an iteration counter and an optional equal-operand early exit.

## Interface
- WIDTH, 16, operand and result width in bits (>= 2)
- ITER_W, 17, width of iteration counter (saturating)
- EARLY_EQ, 0, 1 = finish as soon as x == y (y != 0); 0 = plain subtract/swap to y == 0
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- start  input  1  request; sampled only while idle (`busy` = 0)
- a_in  input  WIDTH  first operand, captured with accepted `start`
- b_in  input  WIDTH  second operand, captured with accepted `start`
- busy  output  1  high while computing
- done  output  1  one-cycle pulse, `result` valid
- result  output  WIDTH  gcd, held until next completion or reset
- iters  output  ITER_W  RUN cycles used by last/current operation

## Operation
- Internal registers x, y (WIDTH bits); states IDLE, RUN.
- IDLE: if `start`=1 at an edge: x <= a_in, y <= b_in, iters <= 0, state <= RUN. Otherwise hold.
- RUN, each edge, first matching rule applies (priority order):
  - y == 0: result <= x, done <= 1, state <= IDLE.
  - EARLY_EQ=1 and x == y: result <= x, done <= 1, state <= IDLE.
  - x < y: swap (x <= y, y <= x).
  - else: x <= x - y (unsigned, never underflows since x >= y).
- iters increments on every RUN edge, including the terminating one; saturates at all-ones, never wraps.
- `start` while busy is ignored; operands are not re-captured.
- gcd(0,0) = 0; gcd(v,0) = v; gcd(0,v) = v (via one swap).
- `busy` = (state == RUN), registered.

## Timing
- Reset (reset=0, async): state IDLE, x=y=0, busy=0, done=0, result=0, iters=0. Mid-operation reset aborts with no `done`; first accepted start after release begins a fresh operation.
- Start accepted at edge k: busy=1 from after edge k. First RUN step at edge k+1.
- Operation needing N RUN steps: terminating step at edge k+N; after it busy=0, done=1, result and iters valid. done drops after edge k+N+1.
- Back-to-back: `start` high in the cycle done=1 is accepted (state is IDLE); result/iters keep the previous values until the new completion, except iters clears on accept.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert reset mid-RUN on a=65535, b=1 -> busy, done, result, iters all 0 immediately; no done pulse afterwards; then start a=9,b=6 completes correctly (result 3).
- EARLY_EQ=0, a=12, b=8: steps sub, swap, sub, sub, swap, finish -> done 6 cycles after start edge, result=4, iters=6.
- EARLY_EQ=1, a=12, b=8: sub, swap, sub, finish on equal -> done 4 cycles after start edge, result=4, iters=4.
- Zero operands: (0,0) -> result 0, iters 1; (7,0) -> result 7, iters 1; (0,5) -> result 5, iters 2.
- Handshake: start held high during busy with different operands -> ignored, result of first operation unchanged; start asserted in the done cycle -> accepted, second result correct.
- Saturation: WIDTH=8, ITER_W=4, a=255, b=1 -> result 1, iters=15 (saturated), done exactly once.
